// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit serializer.
package uart_tx_serializer_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  // Level of the serial line between frames and during stop bits.
  localparam logic LINE_IDLE = 1'b1;

  // Parity mode selectors.
  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_shifter.sv
// DBITS-wide transmit shift register with parity capture at load time.
module uart_tx_shifter
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned DBITS      = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [DBITS-1:0] data,
  output logic             lsb,
  output logic             parity
);

  localparam logic PAR_SEL = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

  logic [DBITS-1:0] shift_q;
  logic             parity_q;

  // Load a new word (and its parity) or shift it right one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else if (load) begin
      shift_q  <= data;
      parity_q <= (^data) ^ PAR_SEL;
    end else if (shift_en) begin
      shift_q  <= {1'b0, shift_q[DBITS-1:1]};
    end
  end

  assign lsb    = shift_q[0];
  assign parity = parity_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: valid/ready byte intake, tick-aligned LSB-first framing.
module uart_tx_serializer
  import uart_tx_serializer_pkg::*;
#(
  parameter int unsigned DBITS      = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refclk,
  input  logic [DBITS-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             txd,
  output logic             busy
);

  localparam int unsigned    CNT_W     = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DBITS - 1);
  localparam logic           LAST_STOP = (STOP_BITS > 1);

  state_t           state, state_next;
  logic             txd_q, txd_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic             stop_cnt, stop_cnt_next;
  logic             load, shift_en;
  logic             lsb, parity_bit;

  uart_tx_shifter #(
    .DBITS      (DBITS),
    .PARITY_ODD (PARITY_ODD)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .data     (tx_data),
    .lsb      (lsb),
    .parity   (parity_bit)
  );

  // Next-state, line level and counter updates; everything holds between ticks.
  // The shifter advances as each bit is launched, so lsb is always the next bit to send.
  always_comb begin
    state_next    = state;
    txd_next      = txd_q;
    bit_cnt_next  = bit_cnt;
    stop_cnt_next = stop_cnt;
    load          = 1'b0;
    shift_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          load       = 1'b1;
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (refclk) begin
          txd_next   = 1'b0;
          state_next = S_START;
        end
      end
      S_START: begin
        if (refclk) begin
          txd_next     = lsb;
          shift_en     = 1'b1;
          bit_cnt_next = '0;
          state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (refclk) begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              txd_next   = parity_bit;
              state_next = S_PARITY;
            end else begin
              txd_next      = LINE_IDLE;
              stop_cnt_next = 1'b0;
              state_next    = S_STOP;
            end
          end else begin
            txd_next     = lsb;
            shift_en     = 1'b1;
            bit_cnt_next = bit_cnt + CNT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (refclk) begin
          txd_next      = LINE_IDLE;
          stop_cnt_next = 1'b0;
          state_next    = S_STOP;
        end
      end
      S_STOP: begin
        if (refclk) begin
          if (stop_cnt == LAST_STOP) begin
            stop_cnt_next = 1'b0;
            state_next    = S_IDLE;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        txd_next   = LINE_IDLE;
        state_next = S_IDLE;
      end
    endcase
  end

  // State, registered line output and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      txd_q    <= LINE_IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_next;
      txd_q    <= txd_next;
      bit_cnt  <= bit_cnt_next;
      stop_cnt <= stop_cnt_next;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

endmodule
